// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if
//   Command handshake into the keypad emulator.
//   in_valid : key command present on in_key
//   in_key   : 4-bit keycode (0-9, A=10, B=11, C=12, D=13, *=14, #=15)
//   in_ready : emulator FIFO can accept a command
//   master drives the command; slave (the emulator) returns in_ready.
interface keypad_emulator_if;
  logic       in_valid;
  logic [3:0] in_key;
  logic       in_ready;

  modport master (output in_valid, output in_key, input in_ready);
  modport slave  (input in_valid, input in_key, output in_ready);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Emulates a 4x4 matrix keypad in front of a row-strobing scanner.
//   Key commands are queued in a 4-entry FIFO; each key is held pressed
//   for HOLD_CYCLES clocks, then released for GAP_CYCLES clocks (plus one
//   IDLE clock before the next press).
//   Ports:
//     clk    : clock, rising edge
//     rst    : synchronous active-high reset
//     bus    : command handshake (in_valid, in_key, in_ready)
//     rows   : active-low row strobes from the scanner
//     cols   : active-low column returns, registered (1 = released)
//     active : high while a key is being pressed
//     busy   : high while a key is in progress or commands are queued
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES  = 2048
) (
  input  logic               clk,
  input  logic               rst,
  keypad_emulator_if.slave   bus,
  input  logic [3:0]         rows,
  output logic [3:0]         cols,
  output logic               active,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] counter;
  logic [3:0]  key_reg;

  logic [3:0]  fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  logic        full;
  logic        push;
  logic        pop;
  logic [1:0]  key_row;
  logic [1:0]  key_col;

  assign full         = (count == 3'd4);
  assign bus.in_ready = !full && !rst;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == IDLE) && (count != 3'd0);

  assign active = (state == PRESS) && !rst;
  assign busy   = ((state != IDLE) || (count != 3'd0)) && !rst;

  // Keypad position {row, col} of the held key.
  always_comb begin
    {key_row, key_col} = 4'b0000;
    case (key_reg)
      4'd1:    {key_row, key_col} = 4'b0000;
      4'd2:    {key_row, key_col} = 4'b0001;
      4'd3:    {key_row, key_col} = 4'b0010;
      4'd10:   {key_row, key_col} = 4'b0011;
      4'd4:    {key_row, key_col} = 4'b0100;
      4'd5:    {key_row, key_col} = 4'b0101;
      4'd6:    {key_row, key_col} = 4'b0110;
      4'd11:   {key_row, key_col} = 4'b0111;
      4'd7:    {key_row, key_col} = 4'b1000;
      4'd8:    {key_row, key_col} = 4'b1001;
      4'd9:    {key_row, key_col} = 4'b1010;
      4'd12:   {key_row, key_col} = 4'b1011;
      4'd14:   {key_row, key_col} = 4'b1100;
      4'd0:    {key_row, key_col} = 4'b1101;
      4'd15:   {key_row, key_col} = 4'b1110;
      default: {key_row, key_col} = 4'b1111; // D
    endcase
  end

  // FIFO storage needs no reset: count/pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.in_key;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      key_reg <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cols    <= '1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      // Only the held key's row matters; other low rows are ignored.
      if ((state == PRESS) && !rows[key_row]) begin
        cols <= ~(4'b0001 << key_col);
      end else begin
        cols <= '1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            key_reg <= fifo_mem[rd_ptr];
            counter <= 16'(HOLD_CYCLES - 1);
            state   <= PRESS;
          end
        end
        PRESS: begin
          if (counter == '0) begin
            counter <= 16'(GAP_CYCLES - 1);
            state   <= GAP;
          end else begin
            counter <= counter - 16'd1;
          end
        end
        GAP: begin
          if (counter == '0) begin
            state <= IDLE;
          end else begin
            counter <= counter - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4096: number of clk cycles a key stays pressed; legal range 1..65535.
REQ-002 SHALL have parameter GAP_CYCLES, default 2048: number of clk cycles of forced release after each press; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  key command present on in_key.
REQ-006 SHALL have port in_key  input  4  keycode, using the team keypad code: 0-9, A=10, B=11, C=12, D=13, *=14, #=15.
REQ-007 SHALL have port in_ready  output  1  command FIFO can accept a command.
REQ-008 SHALL have port rows  input  4  active-low row strobes from the keypad scanner.
REQ-009 SHALL have port cols  output  4  active-low column returns to the scanner; 1 means released.
REQ-010 SHALL have port active  output  1  high while the FSM is in PRESS.
REQ-011 SHALL have port busy  output  1  high when the FSM is not IDLE or the FIFO is not empty.

Function
REQ-012 SHALL buffer commands in a 4-entry FIFO; a push occurs when in_valid && in_ready at a clock edge.
REQ-013 SHALL drive in_ready = !full && !rst; when full, in_valid is ignored and no data is lost or overwritten.
REQ-014 SHALL allow a push and a pop in the same cycle; the FIFO count is then unchanged.
REQ-015 SHALL implement FSM states IDLE, PRESS and GAP.
REQ-016 SHALL, in IDLE with the FIFO non-empty, pop the head into key_reg, load the counter with HOLD_CYCLES-1, and enter PRESS on the next edge.
REQ-017 SHALL, in IDLE with the FIFO empty, remain in IDLE.
REQ-018 SHALL, in PRESS, decrement the counter; at 0 it SHALL load GAP_CYCLES-1 and enter GAP. PRESS therefore lasts exactly HOLD_CYCLES cycles.
REQ-019 SHALL, in GAP, decrement the counter; at 0 it SHALL enter IDLE. GAP therefore lasts exactly GAP_CYCLES cycles.
REQ-020 SHALL map key_reg to (row r, column c) as follows:
- 1→(0,0), 2→(0,1), 3→(0,2), A→(0,3)
- 4→(1,0), 5→(1,1), 6→(1,2), B→(1,3)
- 7→(2,0), 8→(2,1), 9→(2,2), C→(2,3)
- *→(3,0), 0→(3,1), #→(3,2), D→(3,3)
REQ-021 SHALL register cols every cycle as follows:
- if state==PRESS and rows[r]==0, cols = ~(4'b0001<<c);
- otherwise cols = 4'b1111.
- Latency from rows (or state) to cols is 1 cycle.
REQ-022 SHALL pull exactly one cols bit low when the condition in REQ-021 holds; other rows being low at the same time has no effect on cols.
REQ-023 SHALL keep cols at 4'b1111 in IDLE and GAP regardless of rows.
REQ-024 SHALL give each key a released gap of GAP_CYCLES+1 cycles before the next press, because IDLE lasts 1 cycle between GAP and the next PRESS.
REQ-025 SHALL drive active and busy combinationally from the registered state and the FIFO count.
REQ-026 SHALL use FIFO pointers that wrap modulo 4 and a 3-bit count in the range 0..4.

Reset
REQ-027 SHALL, while rst is high at an edge, set state=IDLE, counter=0, FIFO count=0, pointers=0, key_reg=0 and cols=4'b1111.
REQ-028 SHALL drive in_ready, active and busy to 0 while rst is high.
REQ-029 SHALL, on rst asserted mid-PRESS or mid-GAP, abort the press with cols=4'b1111 on the following cycle and discard all queued commands.
REQ-030 SHALL, on rst deasserted, have in_ready=1 and busy=0 in the first cycle.

Verification (bench parameters HOLD_CYCLES=8, GAP_CYCLES=4)
REQ-031 SHALL cover: push key 5 in cycle t, rows held at 4'b1101 -> state PRESS t+2..t+9; cols=4'b1101 for cycles t+3..t+10; cols=4'b1111 from t+11.
REQ-032 SHALL cover: key 0 pressed, rows cycling 1110→1101→1011→0111 with one row per cycle -> cols=4'b1101 only in the cycle after rows=4'b0111, otherwise 4'b1111.
REQ-033 SHALL cover: keys 1 then # pushed back-to-back -> cols=4'b1110 (with row0 low) for 8 cycles, then 5 released cycles, then cols=4'b1011 (with row3 low) for 8 cycles; busy falls after the second GAP.
REQ-034 SHALL cover: in_valid held high with 6 distinct keys from IDLE -> 5 accepted (the first is popped immediately); in_ready=0 with the 6th stalled; the 6th is accepted the cycle after the next pop; keys are emitted in push order.
REQ-035 SHALL cover: rst pulsed for 1 cycle during PRESS of key 9 with 3 keys queued -> cols=4'b1111 next cycle, busy=0, no further presses without new pushes.
REQ-036 SHALL cover: pair the block with the keypad scanner, push each of keys 0..15 -> the scanner's keycode output equals each pushed key in turn.
